// File: rtl/cfq_mult.sv
// cfq_mult: two-stage pipelined 8x4 multiplier; ports clk, rst (async active-low), a[7:0], b[3:0] -> out = P[7:0], c_out = {ext, P[11:8]}; define CFQ_SIGNED_EN for two's complement operands
module cfq_mult (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [3:0] b,
  output logic [7:0] out,
  output logic [7:0] c_out
);
  logic [7:0]  a_q;
  logic [3:0]  b_q;
  logic [11:0] ext;
  logic [11:0] pp [4];
  logic [11:0] pp_q [4];
  logic [11:0] p;
  logic [3:0]  hi;
`ifdef CFQ_SIGNED_EN
  assign ext = {{4{a[7]}}, a};
  assign hi  = {4{p[11]}};
`else
  assign ext = {4'b0, a};
  assign hi  = 4'b0;
`endif
  always_comb begin
    for (int i = 0; i < 4; i++) pp[i] = b[i] ? ext << i : '0;
`ifdef CFQ_SIGNED_EN
    pp[3] = b[3] ? -(ext << 3) : '0;
`endif
  end
  assign p = (a_q == '0 || b_q == '0) ? '0 : pp_q[0] + pp_q[1] + pp_q[2] + pp_q[3];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      pp_q  <= '{default: '0};
      out   <= '0;
      c_out <= '0;
    end else begin
      a_q   <= a;
      b_q   <= b;
      pp_q  <= pp;
      out   <= p[7:0];
      c_out <= {hi, p[11:8]};
    end
  end
endmodule

// File: tb/tb_cfq_mult.sv
// tb_cfq_mult: scoreboard bench for cfq_mult with directed vectors
module tb_cfq_mult;
  logic       clk = 0;
  logic       rst = 0;
  logic [7:0] a = 8'hFF;
  logic [3:0] b = 4'hF;
  logic [7:0] out, c_out;
  typedef struct {
    int         due;
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] eo;
    logic [7:0] ec;
  } exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0, edge_cnt = 0;
  cfq_mult dut (.clk(clk), .rst(rst), .a(a), .b(b), .out(out), .c_out(c_out));
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;
  task automatic chk(input string name, input logic [7:0] go, gc, eo, ec);
    tests++;
    if (go !== eo || gc !== ec) begin
      fails++;
      $display("FAIL %s: got out=%h c_out=%h, want out=%h c_out=%h", name, go, gc, eo, ec);
    end
  endtask
  task automatic issue(input logic [7:0] av, input logic [3:0] bv, input logic [7:0] eo, ec);
    @(negedge clk);
    a = av;
    b = bv;
    sb.push_back('{edge_cnt + 2, av, bv, eo, ec});
  endtask
  task automatic release_rst();
    @(negedge clk);
    rst = 1;
    a = 0;
    b = 0;
    @(negedge clk);
    chk("post_release_edge1", out, c_out, 8'h00, 8'h00);
    @(negedge clk);
    chk("post_release_edge2", out, c_out, 8'h00, 8'h00);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst && sb.size() > 0 && sb[0].due == edge_cnt) begin
      e = sb.pop_front();
      chk($sformatf("prod_%h_x_%h", e.a, e.b), out, c_out, e.eo, e.ec);
    end
  end
  initial begin
    #1 chk("rst_immediate", out, c_out, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_hold", out, c_out, 8'h00, 8'h00);
    end
    release_rst();
    issue(8'h1F, 4'h2, 8'h3E, 8'h00);
    issue(8'h1D, 4'h3, 8'h57, 8'h00);
`ifdef CFQ_SIGNED_EN
    issue(8'hFF, 4'hF, 8'h01, 8'h00);
    issue(8'h80, 4'h7, 8'h80, 8'hFC);
`else
    issue(8'hFF, 4'hF, 8'hF1, 8'h0E);
`endif
    issue(8'h10, 4'h4, 8'h40, 8'h00);
    issue(8'h03, 4'h5, 8'h0F, 8'h00);
    issue(8'h00, 4'hF, 8'h00, 8'h00);
    issue(8'hA5, 4'h0, 8'h00, 8'h00);
    issue(8'h80, 4'h8, 8'h00, 8'h04);
    issue(8'h7F, 4'h6, 8'hFA, 8'h02);
    issue(8'h01, 4'h1, 8'h01, 8'h00);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d pending, want 0", sb.size());
    end
    issue(8'hFF, 4'hF, 8'hF1, 8'h0E);
    @(posedge clk);
    #2 rst = 0;
    sb.delete();
    #1 chk("midop_rst_immediate", out, c_out, 8'h00, 8'h00);
    @(negedge clk);
    chk("midop_rst_hold", out, c_out, 8'h00, 8'h00);
    release_rst();
    issue(8'h0C, 4'h3, 8'h24, 8'h00);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL final_drain: %0d pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cfq_mult.md
CFQ_MULT -- requirements
Module: cfq

Interface
REQ-001 Parameters: none; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock, all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; rst=0 clears all state immediately.
REQ-004 a  input  8  multiplicand, unsigned by default.
REQ-005 b  input  4  multiplier, unsigned by default.
REQ-006 out  output  8  product bits [7:0], registered.
REQ-007 c_out  output  8  product bits [11:4+8-...] i.e. upper product bits P[11:8] in c_out[3:0]; c_out[7:4] is extension.

Function
REQ-008 Full product P = a x b is 12 bits wide; out SHALL equal P[7:0].
REQ-009 c_out[3:0] SHALL equal P[11:8]; c_out[7:4] SHALL be 0 in unsigned mode.
REQ-010 Stage 1 SHALL register a, b and the four partial products (a AND b[i]) << i on every rising clk edge.
REQ-011 Stage 2 SHALL register the sum of the stage-1 partial products into {c_out, out} on the next rising edge.
REQ-012 Latency SHALL be exactly 2 clk rising edges from operand sampling to valid outputs.
REQ-013 The pipeline SHALL accept new operands on every cycle (throughput 1 per cycle) with no handshake.
REQ-014 Operands changing every cycle SHALL yield the matching product 2 cycles later per sample, with no cross-sample mixing.
REQ-015 Zero operands: a=0 or b=0 SHALL give out=0x00, c_out=0x00.
REQ-016 Maximum unsigned case a=0xFF, b=0xF SHALL give P=0xEF1: out=0xF1, c_out=0x0E, with no truncation.
REQ-017 Outputs SHALL hold their value between edges, with no combinational path from a/b to out/c_out.

Reset
REQ-018 While rst=0, all pipeline registers, out and c_out SHALL be 0x00 regardless of clk.
REQ-019 Reset assertion mid-operation SHALL discard in-flight products; no stale product may appear after release.
REQ-020 After rst rises, the first rising edge SHALL sample operands; outputs remain 0 until the second edge.

Configuration
REQ-021 Macro CFQ_SIGNED_EN:
- When defined, a and b are two's complement.
- P is the 12-bit signed product.
- c_out[7:4] is the sign extension of P[11].
REQ-022 Without CFQ_SIGNED_EN, operation is unsigned as in REQ-008..REQ-016.
REQ-023 Under CFQ_SIGNED_EN, a=0xFF, b=0xF (-1 x -1) SHALL give out=0x01, c_out=0x00.
REQ-024 Under CFQ_SIGNED_EN, a=0x80, b=0x7 (-128 x 7 = -896) SHALL give out=0x80, c_out=0xFC.

Verification
REQ-025 Reset check: rst=0 with clk toggling and a=0xFF, b=0xF -> out=0x00, c_out=0x00 throughout.
REQ-026 Basic product: release reset, a=0x1F, b=0x2 -> out=0x3E, c_out=0x00 at the 2nd rising edge after sampling.
REQ-027 Operand change: then a=0x1D, b=0x3 -> out=0x57, c_out=0x00 two edges after sampling.
REQ-028 Overflow into c_out: a=0xFF, b=0xF -> out=0xF1, c_out=0x0E (unsigned build).
REQ-029 Back-to-back samples:
- Cycle n: a=0x10, b=0x4.
- Cycle n+1: a=0x03, b=0x5.
- Required: out=0x40 at edge n+2, then out=0x0F at edge n+3.
REQ-030 Mid-operation reset: assert rst one cycle after sampling a=0xFF, b=0xF -> outputs 0x00 immediately and after release until new samples mature.
